pipe_stage: RTL and testbench

Parametrised elastic pipeline register that replaces the fixed IF/ID, ID/EX, EX/MEM and MEM/WB latches of the five-stage CPU. Each instance carries one DATA_W-bit payload per beat under a valid/ready handshake, supports stall (back-pressure) and flush (bubble insertion on branch or exception), and keeps a saturating stall-cycle counter for performance debug. The CPU top instantiates one per stage boundary and packs control bits, operands and rd into data_i.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/pipe_stage_sat_counter.sv | 34 +++
 rtl/pipe_stage.sv | 111 +++++++++++
 tb/tb_pipe_stage.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_pkg : shared state encoding and width defaults for pipe_stage  |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
package pipe_pkg;

  localparam int XLEN      = 32;
  localparam int REGADDR_W = 5;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'b00,
    PS_FULL  = 2'b01,
    PS_SKID  = 2'b10
  } pipe_state_e;

endpackage
`default_nettype wire

// File: rtl/pipe_stage_sat_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sat_counter : up-counter that sticks at all-ones, synchronous clear |
// | Revision    : 1.0                                                   |
// +--------------------------------------------------------------------+
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_stage : elastic valid/ready pipeline register with flush and   |
// |              saturating stall counter; PIPE_STAGE_SKID_EN enables   |
// |              the registered-ready two-entry skid buffer.            |
// | Revision   : 1.0                                                    |
// +--------------------------------------------------------------------+
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = XLEN,
  parameter logic [DATA_W-1:0] RESET_DATA = '0,
  parameter int                CNT_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  pipe_state_e       state_q;
  logic              valid_q;
  logic [DATA_W-1:0] main_q;
`ifdef PIPE_STAGE_SKID_EN
  logic              ready_q;
  logic [DATA_W-1:0] skid_q;
`endif

  // Flush only resets control state; payload registers keep stale data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= PS_EMPTY;
      valid_q <= 1'b0;
      main_q  <= RESET_DATA;
`ifdef PIPE_STAGE_SKID_EN
      ready_q <= 1'b1;
`endif
    end else if (flush_i) begin
      state_q <= PS_EMPTY;
      valid_q <= 1'b0;
`ifdef PIPE_STAGE_SKID_EN
      ready_q <= 1'b1;
`endif
    end else begin
      case (state_q)
        PS_EMPTY: begin
          if (valid_i) begin
            main_q  <= data_i;
            state_q <= PS_FULL;
            valid_q <= 1'b1;
          end
        end
        PS_FULL: begin
          if (valid_i && ready_i) begin
            main_q <= data_i;
          end else if (ready_i) begin
            state_q <= PS_EMPTY;
            valid_q <= 1'b0;
`ifdef PIPE_STAGE_SKID_EN
          end else if (valid_i) begin
            skid_q  <= data_i;
            state_q <= PS_SKID;
            ready_q <= 1'b0;
`endif
          end
        end
`ifdef PIPE_STAGE_SKID_EN
        PS_SKID: begin
          if (ready_i) begin
            main_q  <= skid_q;
            state_q <= PS_FULL;
            ready_q <= 1'b1;
          end
        end
`endif
        default: begin
          state_q <= PS_EMPTY;
          valid_q <= 1'b0;
`ifdef PIPE_STAGE_SKID_EN
          ready_q <= 1'b1;
`endif
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  assign ready_o = ready_q;
`else
  assign ready_o = ready_i | ~valid_q;
`endif
  assign valid_o = valid_q;
  assign data_o  = main_q;

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .inc_i (valid_q & ~ready_i),
    .cnt_o (stall_cnt_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pipe_stage : self-checking bench, queue-based reference model    |
// | Revision      : 1.0                                                 |
// +--------------------------------------------------------------------+
module tb_pipe_stage;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              flush_i = 1'b0;
  logic              valid_i = 1'b0;
  logic              ready_o;
  logic [DATA_W-1:0] data_i = '0;
  logic              valid_o;
  logic              ready_i = 1'b0;
  logic [DATA_W-1:0] data_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  int checks = 0;
  int fails  = 0;

  // Reference model: the held beats in arrival order plus a stall count.
  logic [DATA_W-1:0] mq[$];
  int                m_cnt = 0;
  bit                accepted;

  always #5 clk_i = ~clk_i;

  pipe_stage #(
    .DATA_W     (DATA_W),
    .RESET_DATA ('0),
    .CNT_W      (CNT_W)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .data_i      (data_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .data_o      (data_o),
    .stall_cnt_o (stall_cnt_o)
  );

  function automatic bit m_valid();
    return mq.size() != 0;
  endfunction

  function automatic bit m_ready();
`ifdef PIPE_STAGE_SKID_EN
    return mq.size() < 2;
`else
    return (mq.size() == 0) || ready_i;
`endif
  endfunction

  task automatic tick();
    bit mv;
    bit mr;
    mv = m_valid();
    mr = m_ready();
    if (!rst_i && mv && !ready_i && m_cnt < CMAX) m_cnt++;
    @(posedge clk_i);
    accepted = !rst_i && !flush_i && valid_i && mr;
    if (rst_i) begin
      mq.delete();
      m_cnt = 0;
    end else if (flush_i) begin
      mq.delete();
    end else begin
      if (mv && ready_i) void'(mq.pop_front());
      if (valid_i && mr) mq.push_back(data_i);
    end
    #1;
  endtask

  task automatic drive(input bit v, input logic [DATA_W-1:0] d, input bit r, input bit f);
    valid_i = v;
    data_i  = d;
    ready_i = r;
    flush_i = f;
    #1;
  endtask

  task automatic do_reset();
    drive(0, '0, 0, 0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    drive(0, '0, 0, 0);
    checks++; if (valid_o !== 1'b0) begin fails++; $display("FAIL reset valid_o got %b exp 0", valid_o); end
    checks++; if (ready_o !== 1'b1) begin fails++; $display("FAIL reset ready_o got %b exp 1", ready_o); end
    checks++; if (data_o !== 8'h00) begin fails++; $display("FAIL reset data_o got %h exp 00", data_o); end
    checks++; if (stall_cnt_o !== 4'd0) begin fails++; $display("FAIL reset stall_cnt got %0d exp 0", stall_cnt_o); end
    tick();
  endtask

  task automatic test_streaming();
    logic [DATA_W-1:0] beats[3] = '{8'h11, 8'h22, 8'h33};
    logic [DATA_W-1:0] got[$];
    do_reset();
    for (int c = 0; c < 6; c++) begin
      drive(c < 3, (c < 3) ? beats[c] : 8'h00, 1'b1, 1'b0);
      checks++; if (valid_o !== m_valid()) begin fails++; $display("FAIL stream valid_o got %b exp %b", valid_o, m_valid()); end
      checks++; if (ready_o !== m_ready()) begin fails++; $display("FAIL stream ready_o got %b exp %b", ready_o, m_ready()); end
      if (m_valid()) begin checks++; if (data_o !== mq[0]) begin fails++; $display("FAIL stream data_o got %h exp %h", data_o, mq[0]); end end
      if (c >= 1 && c <= 3) begin
        checks++; if (!valid_o || data_o !== beats[c-1]) begin fails++; $display("FAIL stream beat%0d got v=%b d=%h exp %h", c, valid_o, data_o, beats[c-1]); end
      end
      if (valid_o) got.push_back(data_o);
      tick();
    end
    checks++; if (got.size() != 3) begin fails++; $display("FAIL stream count got %0d exp 3", got.size()); end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] pend[$];
    logic [DATA_W-1:0] got[$];
    do_reset();
    pend.push_back(8'h0A);
    pend.push_back(8'h0B);
    for (int c = 0; c < 10; c++) begin
      drive(pend.size() != 0, (pend.size() != 0) ? pend[0] : 8'h00, !(c >= 1 && c <= 3), 1'b0);
      checks++; if (valid_o !== m_valid()) begin fails++; $display("FAIL bp valid_o got %b exp %b", valid_o, m_valid()); end
      checks++; if (ready_o !== m_ready()) begin fails++; $display("FAIL bp ready_o got %b exp %b", ready_o, m_ready()); end
      checks++; if (stall_cnt_o !== CNT_W'(m_cnt)) begin fails++; $display("FAIL bp stall_cnt got %0d exp %0d", stall_cnt_o, m_cnt); end
      if (m_valid()) begin checks++; if (data_o !== mq[0]) begin fails++; $display("FAIL bp data_o got %h exp %h", data_o, mq[0]); end end
      if (c == 3) begin
        checks++; if (ready_o !== 1'b0 || data_o !== 8'h0A) begin fails++; $display("FAIL bp held got rdy=%b d=%h exp rdy=0 d=0a", ready_o, data_o); end
      end
      if (c == 4) begin
        checks++; if (stall_cnt_o !== 4'd3) begin fails++; $display("FAIL bp stall3 got %0d exp 3", stall_cnt_o); end
      end
      if (valid_o && ready_i) got.push_back(data_o);
      tick();
      if (accepted) void'(pend.pop_front());
    end
    checks++; if (got.size() != 2 || got[0] !== 8'h0A || got[1] !== 8'h0B) begin
      fails++; $display("FAIL bp order got %0d beats exp 0a,0b", got.size());
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int c = 0; c < 9; c++) begin
      case (c)
        0:       drive(1'b1, 8'h0A, 1'b1, 1'b0);
        1:       drive(1'b1, 8'h0B, 1'b0, 1'b0);
        2:       drive(1'b1, 8'h0C, 1'b0, 1'b1);
        default: drive(1'b0, 8'h00, 1'b1, 1'b0);
      endcase
      checks++; if (valid_o !== m_valid()) begin fails++; $display("FAIL flush valid_o got %b exp %b", valid_o, m_valid()); end
      checks++; if (ready_o !== m_ready()) begin fails++; $display("FAIL flush ready_o got %b exp %b", ready_o, m_ready()); end
      checks++; if (stall_cnt_o !== CNT_W'(m_cnt)) begin fails++; $display("FAIL flush stall_cnt got %0d exp %0d", stall_cnt_o, m_cnt); end
      if (c == 3) begin
        checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1 || stall_cnt_o !== 4'd2) begin
          fails++; $display("FAIL flush after got v=%b r=%b cnt=%0d exp v=0 r=1 cnt=2", valid_o, ready_o, stall_cnt_o);
        end
      end
      if (c >= 3) begin
        checks++; if (valid_o !== 1'b0) begin fails++; $display("FAIL flush leak got valid data %h exp none", data_o); end
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    do_reset();
    drive(1'b1, 8'h5A, 1'b1, 1'b0);
    tick();
    for (int c = 0; c < 20; c++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      checks++; if (stall_cnt_o !== CNT_W'(m_cnt)) begin fails++; $display("FAIL sat stall_cnt got %0d exp %0d", stall_cnt_o, m_cnt); end
      checks++; if (data_o !== 8'h5A || valid_o !== 1'b1) begin fails++; $display("FAIL sat hold got v=%b d=%h exp v=1 d=5a", valid_o, data_o); end
      tick();
    end
    checks++; if (stall_cnt_o !== 4'd15) begin fails++; $display("FAIL sat max got %0d exp 15", stall_cnt_o); end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    checks++; if (stall_cnt_o !== 4'd15 || valid_o !== 1'b0) begin fails++; $display("FAIL sat keep got cnt=%0d v=%b exp 15,0", stall_cnt_o, valid_o); end
  endtask

  task automatic test_ready_path();
    do_reset();
    drive(1'b1, 8'h21, 1'b1, 1'b0);
    tick();
    drive(1'b1, 8'h42, 1'b0, 1'b0);
`ifdef PIPE_STAGE_SKID_EN
    checks++; if (ready_o !== 1'b1) begin fails++; $display("FAIL rdy_reg low got %b exp 1", ready_o); end
`else
    checks++; if (ready_o !== 1'b0) begin fails++; $display("FAIL rdy_comb low got %b exp 0", ready_o); end
`endif
    drive(1'b1, 8'h42, 1'b1, 1'b0);
    checks++; if (ready_o !== 1'b1) begin fails++; $display("FAIL rdy_comb high got %b exp 1", ready_o); end
    tick();
    checks++; if (valid_o !== 1'b1 || data_o !== 8'h42) begin fails++; $display("FAIL rdy next got v=%b d=%h exp 1,42", valid_o, data_o); end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_random();
    bit                hold = 1'b0;
    logic [DATA_W-1:0] hd   = '0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (!hold) begin
        hold = ($urandom % 3) != 0;
        hd   = DATA_W'($urandom);
      end
      drive(hold, hd, ($urandom % 4) != 0, ($urandom % 16) == 0);
      checks++; if (valid_o !== m_valid()) begin fails++; $display("FAIL rand valid_o c=%0d got %b exp %b", c, valid_o, m_valid()); end
      checks++; if (ready_o !== m_ready()) begin fails++; $display("FAIL rand ready_o c=%0d got %b exp %b", c, ready_o, m_ready()); end
      checks++; if (stall_cnt_o !== CNT_W'(m_cnt)) begin fails++; $display("FAIL rand stall_cnt c=%0d got %0d exp %0d", c, stall_cnt_o, m_cnt); end
      if (m_valid()) begin checks++; if (data_o !== mq[0]) begin fails++; $display("FAIL rand data_o c=%0d got %h exp %h", c, data_o, mq[0]); end end
      tick();
      if (accepted || flush_i) hold = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_saturation();
    test_ready_path();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
